// File: rtl/data_buf_loader_if.sv
// Bundle of the element stream, buffer write port and buffer read/release port
// seen by the row-buffer loader.
interface data_buf_loader_if #(
  parameter int ELEM_BW = 8,
  parameter int MAC_BW  = 128,
  parameter int ROW_CNT = 2
) ();
  localparam int ADDR_W = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;

  // Handshakes: an element transfers on a rising clk edge where in_valid && in_ready;
  // in_data/in_last are only meaningful while in_valid=1. wr_en is a 1-cycle write
  // strobe with no back-pressure. rd_en marks the head row readable; rd_done is a
  // 1-cycle release pulse that only takes effect while rd_en=1.
  logic               in_valid;
  logic               in_ready;
  logic [ELEM_BW-1:0] in_data;
  logic               in_last;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [MAC_BW-1:0]  wr_data;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               rd_done;
  logic [ADDR_W:0]    occ;
  logic               err;

  modport master (
    output in_valid, in_data, in_last, rd_done,
    input  in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, occ, err
  );

  modport slave (
    input  in_valid, in_data, in_last, rd_done,
    output in_ready, wr_en, wr_addr, wr_data, rd_en, rd_addr, occ, err
  );
endinterface

// File: rtl/data_buf_loader.sv
// Packs a narrow element stream into MAC_BW-wide rows, writes them into a ring of
// ROW_CNT buffer rows and presents the oldest committed row to the MAC read side.
module data_buf_loader #(
  parameter int ELEM_BW = 8,
  parameter int MAC_BW  = 128,
  parameter int ROW_CNT = 2
) (
  input logic              clk,
  input logic              rst_n,
  data_buf_loader_if.slave bus
);
  localparam int PACK   = MAC_BW / ELEM_BW;
  localparam int ADDR_W = (ROW_CNT > 1) ? $clog2(ROW_CNT) : 1;
  localparam int CNT_W  = (PACK > 1) ? $clog2(PACK) : 1;

  localparam logic [CNT_W-1:0]  LAST_LANE = CNT_W'(PACK - 1);
  localparam logic [ADDR_W:0]   FULL_OCC  = (ADDR_W + 1)'(ROW_CNT);
  localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(ROW_CNT - 1);

  logic [CNT_W-1:0]   cnt;
  logic [MAC_BW-1:0]  pack;
  logic [ADDR_W-1:0]  head;
  logic [ADDR_W-1:0]  tail;
  logic [ROW_CNT-1:0] vld;
  logic [ADDR_W:0]    occ;
  logic               wr_en;
  logic [ADDR_W-1:0]  wr_addr;
  logic [MAC_BW-1:0]  wr_data;
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic               err;

  logic               in_ready;
  logic               xfer;
  logic               commit;
  logic               rel;
  logic [MAC_BW-1:0]  row_nxt;
  logic [ADDR_W-1:0]  head_nxt;
  logic [ADDR_W-1:0]  tail_nxt;
  logic [ROW_CNT-1:0] vld_nxt;
  logic [ADDR_W:0]    occ_nxt;

  function automatic logic [ADDR_W-1:0] ring_inc(input logic [ADDR_W-1:0] ptr);
    ring_inc = (ptr == LAST_ROW) ? '0 : ptr + 1'b1;
  endfunction

  // occ counts rows from commit until release, so a slot is never reused while held.
  assign in_ready = (occ < FULL_OCC);
  assign xfer     = bus.in_valid && in_ready;
  assign commit   = xfer && ((cnt == LAST_LANE) || bus.in_last);
  assign rel      = bus.rd_done && rd_en;

  always_comb begin
    row_nxt = pack;
    row_nxt[int'(cnt) * ELEM_BW +: ELEM_BW] = bus.in_data;
  end

  always_comb begin
    vld_nxt = vld;
    if (rel)   vld_nxt[head]    = 1'b0;
    if (wr_en) vld_nxt[wr_addr] = 1'b1;
    head_nxt = rel    ? ring_inc(head) : head;
    tail_nxt = commit ? ring_inc(tail) : tail;
    occ_nxt  = occ;
    if (commit && !rel)      occ_nxt = occ + 1'b1;
    else if (rel && !commit) occ_nxt = occ - 1'b1;
  end

  // Packing register and lane counter; both hold while the ring is full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      pack <= '0;
    end else if (commit) begin
      cnt  <= '0;
      pack <= '0;
    end else if (xfer) begin
      cnt  <= cnt + 1'b1;
      pack <= row_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= commit;
      if (commit) begin
        wr_addr <= tail;
        wr_data <= row_nxt;
      end
    end
  end

  // rd_en/rd_addr are registered copies of the post-edge vld[head] and head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head    <= '0;
      tail    <= '0;
      vld     <= '0;
      occ     <= '0;
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      head    <= head_nxt;
      tail    <= tail_nxt;
      vld     <= vld_nxt;
      occ     <= occ_nxt;
      rd_en   <= vld_nxt[head_nxt];
      rd_addr <= head_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      err <= 1'b0;
    else if (bus.rd_done && !rd_en)  err <= 1'b1;
  end

  assign bus.in_ready = in_ready;
  assign bus.wr_en    = wr_en;
  assign bus.wr_addr  = wr_addr;
  assign bus.wr_data  = wr_data;
  assign bus.rd_en    = rd_en;
  assign bus.rd_addr  = rd_addr;
  assign bus.occ      = occ;
  assign bus.err      = err;
endmodule

// File: tb/tb_data_buf_loader.sv
// Directed bench for data_buf_loader with 8-bit elements, 32-bit rows and a 2-row ring.
module tb_data_buf_loader;
  localparam int ELEM_BW = 8;
  localparam int MAC_BW  = 32;
  localparam int ROW_CNT = 2;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  logic [MAC_BW-1:0] mem [ROW_CNT];
  logic [MAC_BW-1:0] exp_q [$];

  data_buf_loader_if #(.ELEM_BW(ELEM_BW), .MAC_BW(MAC_BW), .ROW_CNT(ROW_CNT)) bus ();

  data_buf_loader #(.ELEM_BW(ELEM_BW), .MAC_BW(MAC_BW), .ROW_CNT(ROW_CNT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // external row buffer written through the DUT write port
  always @(posedge clk) if (bus.wr_en) mem[bus.wr_addr] <= bus.wr_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] data, input logic last);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_last  = last;
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.rd_done  = 1'b0;
  endtask

  task automatic pulse_done();
    bus.rd_done = 1'b1;
    tick();
    bus.rd_done = 1'b0;
  endtask

  initial begin
    int elem;
    int cyc;
    logic xfer;
    logic [31:0] row_acc;
    n_tests = 0;
    n_fail  = 0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    bus.rd_done  = 1'b0;
    rst_n = 1'b0;
    tick();
    tick();

    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
    chk("rst_rd_en",    32'(bus.rd_en),    32'd0);
    chk("rst_rd_addr",  32'(bus.rd_addr),  32'd0);
    chk("rst_occ",      32'(bus.occ),      32'd0);
    chk("rst_err",      32'(bus.err),      32'd0);
    rst_n = 1'b1;
    tick();

    // T1: full row of four beats
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h04, 1'b0);
    idle();
    chk("t1_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t1_wr_data", 32'(bus.wr_data), 32'h04030201);
    chk("t1_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("t1_occ",     32'(bus.occ),     32'd1);
    chk("t1_rd_en_early", 32'(bus.rd_en), 32'd0);
    tick();
    chk("t1_wr_en_drop", 32'(bus.wr_en),   32'd0);
    chk("t1_rd_en",      32'(bus.rd_en),   32'd1);
    chk("t1_rd_addr",    32'(bus.rd_addr), 32'd0);
    chk("t1_mem0",       mem[0],           32'h04030201);
    pulse_done();
    chk("t1_rel_occ",     32'(bus.occ),     32'd0);
    chk("t1_rel_rd_en",   32'(bus.rd_en),   32'd0);
    chk("t1_rel_rd_addr", 32'(bus.rd_addr), 32'd1);

    // T2: short burst with in_last, then single-element burst
    send(8'h0A, 1'b0);
    send(8'h0B, 1'b1);
    idle();
    chk("t2_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t2_wr_data", 32'(bus.wr_data), 32'h00000B0A);
    chk("t2_wr_addr", 32'(bus.wr_addr), 32'd1);
    chk("t2_occ",     32'(bus.occ),     32'd1);
    tick();
    chk("t2_rd_en",   32'(bus.rd_en),   32'd1);
    chk("t2_rd_addr", 32'(bus.rd_addr), 32'd1);
    send(8'h0C, 1'b1);
    idle();
    chk("t2_lane0_data", 32'(bus.wr_data), 32'h0000000C);
    chk("t2_lane0_addr", 32'(bus.wr_addr), 32'd0);

    // T3: ring full, held input must not transfer
    chk("t3_occ_full", 32'(bus.occ),      32'd2);
    chk("t3_not_rdy",  32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      send(8'hEE, 1'b0);
      chk("t3_hold_rdy",  32'(bus.in_ready), 32'd0);
      chk("t3_hold_occ",  32'(bus.occ),      32'd2);
      chk("t3_hold_wren", 32'(bus.wr_en),    32'd0);
    end
    idle();
    chk("t3_rd_addr_full", 32'(bus.rd_addr), 32'd1);
    pulse_done();
    chk("t3_rdy_back", 32'(bus.in_ready), 32'd1);
    chk("t3_occ_rel",  32'(bus.occ),      32'd1);
    chk("t3_rd_addr",  32'(bus.rd_addr),  32'd0);
    chk("t3_rd_en",    32'(bus.rd_en),    32'd1);
    chk("t3_mem_head", mem[0],            32'h0000000C);
    pulse_done();
    chk("t3_drain_occ",  32'(bus.occ),   32'd0);
    chk("t3_drain_rden", 32'(bus.rd_en), 32'd0);

    // T4: commit and release on the same edge
    send(8'h10, 1'b0);
    send(8'h11, 1'b0);
    send(8'h12, 1'b0);
    send(8'h13, 1'b0);
    idle();
    chk("t4_a_addr", 32'(bus.wr_addr), 32'd1);
    chk("t4_a_data", 32'(bus.wr_data), 32'h13121110);
    tick();
    chk("t4_a_rd_en", 32'(bus.rd_en), 32'd1);
    send(8'h20, 1'b0);
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    bus.rd_done = 1'b1;
    send(8'h23, 1'b0);
    idle();
    chk("t4_sim_occ",     32'(bus.occ),     32'd1);
    chk("t4_sim_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("t4_sim_wr_data", 32'(bus.wr_data), 32'h23222120);
    chk("t4_sim_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("t4_sim_rd_en",   32'(bus.rd_en),   32'd0);
    tick();
    chk("t4_b_rd_en", 32'(bus.rd_en), 32'd1);
    exp_q.push_back(32'h23222120);

    // T4 continued: ten rows with random release, read order checked
    elem = 0;
    cyc = 0;
    row_acc = '0;
    while ((elem < 40 || exp_q.size() > 0) && cyc < 600) begin
      bus.in_valid = (elem < 40) && bus.in_ready;
      bus.in_data  = 8'(8'h40 + elem);
      bus.in_last  = 1'b0;
      bus.rd_done  = bus.rd_en && ($urandom_range(0, 1) == 1);
      if (bus.rd_done) begin
        if (exp_q.size() > 0) chk("t4_order", mem[bus.rd_addr], exp_q.pop_front());
        else chk("t4_extra_row", 32'd1, 32'd0);
      end
      xfer = bus.in_valid;
      tick();
      if (xfer) begin
        row_acc[(elem % 4) * 8 +: 8] = 8'(8'h40 + elem);
        if (elem % 4 == 3) exp_q.push_back(row_acc);
        elem++;
      end
      cyc++;
    end
    idle();
    chk("t4_timeout",   32'(cyc < 600),     32'd1);
    chk("t4_left_rows", 32'(exp_q.size()),  32'd0);
    chk("t4_end_occ",   32'(bus.occ),       32'd0);

    // T5: release without a valid head
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    pulse_done();
    chk("t5_err",     32'(bus.err),     32'd1);
    chk("t5_occ",     32'(bus.occ),     32'd0);
    chk("t5_rd_addr", 32'(bus.rd_addr), 32'd0);
    chk("t5_rd_en",   32'(bus.rd_en),   32'd0);
    tick();
    tick();
    chk("t5_err_sticky", 32'(bus.err), 32'd1);

    // T6: reset mid-burst drops the partial row
    send(8'h55, 1'b0);
    send(8'h66, 1'b0);
    idle();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_err", 32'(bus.err), 32'd0);
    chk("t6_rst_occ", 32'(bus.occ), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'h21, 1'b0);
    send(8'h22, 1'b0);
    send(8'h23, 1'b0);
    send(8'h24, 1'b0);
    idle();
    chk("t6_wr_en",   32'(bus.wr_en),   32'd1);
    chk("t6_wr_data", 32'(bus.wr_data), 32'h24232221);
    chk("t6_wr_addr", 32'(bus.wr_addr), 32'd0);
    chk("t6_err",     32'(bus.err),     32'd0);
    chk("t6_occ",     32'(bus.occ),     32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
